// File: rtl/alu_bitfield_unit.sv
// alu_bitfield_unit: two-stage pipelined bitfield engine (MASK / EXTRACT / INSERT / CLEAR).
// A field of (size + 1) bits starting at bit 'offset' is built as a mask and then applied
// to the operand. Valid/ready handshakes on both sides let the unit stall on its own.
// Optional build macro ALU_BITFIELD_SEXT_EN adds a 'sext' input that makes EXTRACT
// sign-extend the extracted field.
module alu_bitfield_unit #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [SW-1:0]    size,
    input  logic [SW-1:0]    offset,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] ins,
`ifdef ALU_BITFIELD_SEXT_EN
    input  logic             sext,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic [1:0] OpMask    = 2'b00;
    localparam logic [1:0] OpExtract = 2'b01;
    localparam logic [1:0] OpInsert  = 2'b10;
    localparam logic [1:0] OpClear   = 2'b11;

    // (1 << (sz + 1)) - 1 in WIDTH+1 bits, so sz = WIDTH-1 yields all ones without wrapping.
    function automatic logic [WIDTH-1:0] low_ones(input logic [SW-1:0] sz);
        logic [WIDTH:0] b;
        b = ((WIDTH+1)'(1) << ({1'b0, sz} + (SW+1)'(1))) - (WIDTH+1)'(1);
        return b[WIDTH-1:0];
    endfunction

    // Stage 1 state
    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [SW-1:0]    s1_size;
    logic [SW-1:0]    s1_offset;
    logic [WIDTH-1:0] s1_src;
    logic [WIDTH-1:0] s1_ins;
    logic [WIDTH-1:0] s1_fmask;
`ifdef ALU_BITFIELD_SEXT_EN
    logic             s1_sext;
`endif

    // Stage 2 state
    logic             s2_valid;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] in_fmask;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] s1_base;
    logic [WIDTH-1:0] result_d;
    logic             overflow_d;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Field mask for the incoming request; bits past WIDTH-1 fall off in the truncation.
    always_comb begin
        in_fmask = low_ones(size) << offset;
    end

    // Stage 1 register: capture the request and its mask when the stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= 2'b00;
            s1_size   <= '0;
            s1_offset <= '0;
            s1_src    <= '0;
            s1_ins    <= '0;
            s1_fmask  <= '0;
`ifdef ALU_BITFIELD_SEXT_EN
            s1_sext   <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op     <= op;
                s1_size   <= size;
                s1_offset <= offset;
                s1_src    <= src;
                s1_ins    <= ins;
                s1_fmask  <= in_fmask;
`ifdef ALU_BITFIELD_SEXT_EN
                s1_sext   <= sext;
`endif
            end
        end
    end

    // Apply the registered mask according to the operation and flag truncation.
    always_comb begin
        shifted    = s1_src >> s1_offset;
        s1_base    = low_ones(s1_size);
        overflow_d = ({1'b0, s1_offset} + {1'b0, s1_size}) >= (SW+1)'(WIDTH);
        result_d   = s1_fmask;
        case (s1_op)
            OpMask:    result_d = s1_fmask;
            OpExtract: begin
                result_d = shifted & s1_base;
`ifdef ALU_BITFIELD_SEXT_EN
                // A truncated field reads 0 in its top bit, so it never sign-extends.
                if (s1_sext && shifted[s1_size]) begin
                    result_d = result_d | ~s1_base;
                end
`endif
            end
            OpInsert:  result_d = (s1_src & ~s1_fmask) | ((s1_ins << s1_offset) & s1_fmask);
            OpClear:   result_d = s1_src & ~s1_fmask;
            default:   result_d = s1_fmask;
        endcase
    end

    // Stage 2 register: result payload holds while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result   <= result_d;
                overflow <= overflow_d;
            end
        end
    end

endmodule
